keypad_entry_capture: RTL and testbench



---
 rtl/keypad_entry_capture.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_entry_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_capture.sv
// keypad_entry_capture: conditions the active-low push buttons (2-flop sync +
// debounce), accepts one clean single-key press at a time and shifts each
// accepted digit into a packed one-hot store feeding the 7-segment decoder.
// Entry progress is tracked by a small FSM that signals completion or an
// inter-key timeout to the lock controller.
module keypad_entry_capture #(
  parameter int KEY_WIDTH       = 4,
  parameter int DIGIT_NUMBERS   = 6,
  parameter int PASSWORD_LENGTH = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [KEY_WIDTH-1:0]                 key_n,
  input  logic                                 enable,
  input  logic                                 clearEntry,
  output logic [KEY_WIDTH*DIGIT_NUMBERS-1:0]   keyValueStore,
  output logic [$clog2(PASSWORD_LENGTH+1)-1:0] keyCount,
  output logic                                 keyPressed,
  output logic                                 entryDone,
  output logic                                 entryTimeout
);

  localparam int STORE_W = KEY_WIDTH * DIGIT_NUMBERS;
  localparam int CNT_W   = $clog2(PASSWORD_LENGTH + 1);
  localparam int DB_W    = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TM_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TM_W-1:0]  TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PW_LEN  = CNT_W'(PASSWORD_LENGTH);

  typedef enum logic [1:0] {IDLE, ENTRY, DONE, TIMEOUT} state_t;

  // Input conditioning state
  logic [KEY_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [KEY_WIDTH-1:0] cand_q, cand_d;
  logic [KEY_WIDTH-1:0] debounced_q, debounced_d;
  logic [KEY_WIDTH-1:0] prev_db_q, prev_db_d;
  logic [DB_W-1:0]      db_cnt_q, db_cnt_d;

  // Entry FSM state and registered outputs
  state_t               state_q, state_d;
  logic [STORE_W-1:0]   store_q, store_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TM_W-1:0]      timer_q, timer_d;
  logic                 pressed_q, pressed_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;

  logic                 press_hit;
  logic [STORE_W-1:0]   digit_ext;
  logic [STORE_W-1:0]   store_shift;
  logic [CNT_W-1:0]     count_inc;

  // Synchroniser and debounce: a candidate must stay unchanged long enough
  // before it is promoted to the debounced vector; the counter saturates.
  always_comb begin
    sync1_d     = ~key_n;
    sync2_d     = sync1_q;
    cand_d      = cand_q;
    db_cnt_d    = db_cnt_q;
    debounced_d = debounced_q;
    prev_db_d   = debounced_q;
    if (sync2_q != cand_q) begin
      cand_d   = sync2_q;
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_MAX) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end else begin
      debounced_d = cand_q;
    end
  end

  // A press is a transition from all-released straight to exactly one key;
  // chords and partial releases never qualify.
  always_comb begin
    press_hit = (prev_db_q == '0) && (debounced_q != '0) &&
                ((debounced_q & (debounced_q - 1'b1)) == '0);
    digit_ext = '0;
    digit_ext[KEY_WIDTH-1:0] = debounced_q;
    store_shift = (store_q << KEY_WIDTH) | digit_ext;
    count_inc   = count_q + 1'b1;
  end

  // Conditioning registers run independently of enable and the FSM so a key
  // held across a clear must be released before it can count again.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      db_cnt_q    <= '0;
      debounced_q <= '0;
      prev_db_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      db_cnt_q    <= db_cnt_d;
      debounced_q <= debounced_d;
      prev_db_q   <= prev_db_d;
    end
  end

  // Entry FSM next state: clear/disable beats timeout, and a press on the
  // expiry cycle beats the timeout.
  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    count_d   = count_q;
    timer_d   = timer_q;
    pressed_d = 1'b0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    if (clearEntry || !enable) begin
      state_d = IDLE;
      store_d = '0;
      count_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          store_d = '0;
          count_d = '0;
          timer_d = '0;
          if (press_hit) begin
            store_d   = digit_ext;
            count_d   = CNT_W'(1);
            pressed_d = 1'b1;
            if (PASSWORD_LENGTH == 1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ENTRY;
            end
          end
        end
        ENTRY: begin
          if (press_hit) begin
            store_d   = store_shift;
            count_d   = count_inc;
            timer_d   = '0;
            pressed_d = 1'b1;
            if (count_inc == PW_LEN) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else if (timer_q == TM_LAST) begin
            state_d = TIMEOUT;
            tmo_d   = 1'b1;
            store_d = '0;
            count_d = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        DONE: begin
          timer_d = '0;
        end
        TIMEOUT: begin
          store_d = '0;
          count_d = '0;
          timer_d = '0;
        end
        default: begin
          state_d = IDLE;
          store_d = '0;
          count_d = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // Entry FSM state register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      store_q   <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      pressed_q <= pressed_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
    end
  end

  assign keyValueStore = store_q;
  assign keyCount      = count_q;
  assign keyPressed    = pressed_q;
  assign entryDone     = done_q;
  assign entryTimeout  = tmo_q;

endmodule

// File: tb/tb_keypad_entry_capture.sv
// Directed testbench for keypad_entry_capture with short debounce/timeout.
module tb_keypad_entry_capture;

  logic        clk;
  logic        reset;
  logic [3:0]  key_n;
  logic        enable;
  logic        clearEntry;
  logic [23:0] keyValueStore;
  logic [2:0]  keyCount;
  logic        keyPressed;
  logic        entryDone;
  logic        entryTimeout;

  int errors;
  int checks;

  // Pulse monitor, updated once per cycle by step()
  int          cyc;
  int          n_press;
  int          n_done;
  int          n_tmo;
  int          press_cyc;
  int          tmo_cyc;
  logic        done_with_press;
  logic [23:0] pstore [8];

  keypad_entry_capture #(
    .KEY_WIDTH(4),
    .DIGIT_NUMBERS(6),
    .PASSWORD_LENGTH(4),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clock(clk),
    .reset(reset),
    .key_n(key_n),
    .enable(enable),
    .clearEntry(clearEntry),
    .keyValueStore(keyValueStore),
    .keyCount(keyCount),
    .keyPressed(keyPressed),
    .entryDone(entryDone),
    .entryTimeout(entryTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (keyPressed) begin
      n_press++;
      press_cyc = cyc;
      if (n_press <= 8) pstore[n_press-1] = keyValueStore;
    end
    if (entryDone) begin
      n_done++;
      done_with_press = keyPressed;
    end
    if (entryTimeout) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
  endtask

  task automatic clear_mon();
    n_press = 0;
    n_done = 0;
    n_tmo = 0;
    press_cyc = 0;
    tmo_cyc = 0;
    done_with_press = 1'b0;
    for (int i = 0; i < 8; i++) pstore[i] = '0;
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    key_n = ~k;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_n = 4'hF;
    clearEntry = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    clear_mon();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_n = 4'hF;
    repeat (2) step();
    checks++; if (keyValueStore !== 24'h0) begin errors++; $display("FAIL reset_store: got %h want %h", keyValueStore, 24'h0); end
    checks++; if (keyCount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", keyCount); end
    checks++; if (keyPressed !== 1'b0) begin errors++; $display("FAIL reset_pressed: got %b want 0", keyPressed); end
    checks++; if (entryDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", entryDone); end
    checks++; if (entryTimeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", entryTimeout); end
    reset = 1'b0;
  endtask

  // Press-to-press spacing (20 cycles) equals the timeout, so presses 2..4
  // land on the expiry cycle and must win over the timeout.
  task automatic test_full_entry();
    logic [3:0]  keys [4];
    logic [23:0] want [4];
    keys = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    want = '{24'h000001, 24'h000012, 24'h000124, 24'h001248};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      hold(keys[i], 10);
      hold(4'b0000, 10);
    end
    checks++; if (n_press !== 4) begin errors++; $display("FAIL full_npress: got %0d want 4", n_press); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pstore[i] !== want[i]) begin errors++; $display("FAIL full_store%0d: got %h want %h", i, pstore[i], want[i]); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL full_ndone: got %0d want 1", n_done); end
    checks++; if (done_with_press !== 1'b1) begin errors++; $display("FAIL full_done_align: got %b want 1", done_with_press); end
    checks++; if (n_tmo !== 0) begin errors++; $display("FAIL full_ntmo: got %0d want 0", n_tmo); end
    checks++; if (keyCount !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", keyCount); end
    // fifth press in DONE is ignored
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    checks++; if (n_press !== 4) begin errors++; $display("FAIL full_fifth_npress: got %0d want 4", n_press); end
    checks++; if (keyValueStore !== 24'h001248) begin errors++; $display("FAIL full_fifth_store: got %h want %h", keyValueStore, 24'h001248); end
    checks++; if (keyCount !== 3'd4) begin errors++; $display("FAIL full_fifth_count: got %0d want 4", keyCount); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      hold(4'b0001, 2);
      hold(4'b0000, 2);
    end
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    checks++; if (n_press !== 1) begin errors++; $display("FAIL bounce_npress: got %0d want 1", n_press); end
    checks++; if (keyValueStore !== 24'h000001) begin errors++; $display("FAIL bounce_store: got %h want %h", keyValueStore, 24'h000001); end
    checks++; if (keyCount !== 3'd1) begin errors++; $display("FAIL bounce_count: got %0d want 1", keyCount); end
  endtask

  task automatic test_timeout();
    do_reset();
    hold(4'b0010, 10);
    hold(4'b0000, 25);
    checks++; if (n_tmo !== 1) begin errors++; $display("FAIL tmo_ntmo: got %0d want 1", n_tmo); end
    checks++; if (tmo_cyc - press_cyc !== 20) begin errors++; $display("FAIL tmo_delay: got %0d want 20", tmo_cyc - press_cyc); end
    checks++; if (keyValueStore !== 24'h0) begin errors++; $display("FAIL tmo_store: got %h want %h", keyValueStore, 24'h0); end
    checks++; if (keyCount !== 3'd0) begin errors++; $display("FAIL tmo_count: got %0d want 0", keyCount); end
    // ignored while parked in TIMEOUT
    hold(4'b0100, 10);
    hold(4'b0000, 10);
    checks++; if (n_press !== 1) begin errors++; $display("FAIL tmo_ignored_npress: got %0d want 1", n_press); end
    checks++; if (keyValueStore !== 24'h0) begin errors++; $display("FAIL tmo_ignored_store: got %h want %h", keyValueStore, 24'h0); end
    clearEntry = 1'b1;
    step();
    clearEntry = 1'b0;
    clear_mon();
    hold(4'b0010, 10);
    hold(4'b0000, 10);
    checks++; if (n_press !== 1) begin errors++; $display("FAIL tmo_after_clear_npress: got %0d want 1", n_press); end
    checks++; if (keyValueStore !== 24'h000002) begin errors++; $display("FAIL tmo_after_clear_store: got %h want %h", keyValueStore, 24'h000002); end
  endtask

  task automatic test_two_keys();
    do_reset();
    hold(4'b0101, 10);
    hold(4'b0000, 10);
    checks++; if (n_press !== 0) begin errors++; $display("FAIL chord_npress: got %0d want 0", n_press); end
    checks++; if (keyValueStore !== 24'h0) begin errors++; $display("FAIL chord_store: got %h want %h", keyValueStore, 24'h0); end
    hold(4'b1000, 10);
    hold(4'b0000, 10);
    checks++; if (n_press !== 1) begin errors++; $display("FAIL chord_next_npress: got %0d want 1", n_press); end
    checks++; if (keyValueStore !== 24'h000008) begin errors++; $display("FAIL chord_next_store: got %h want %h", keyValueStore, 24'h000008); end
  endtask

  // clearEntry spans the cycle where key 1 is first accepted; the key stays
  // held after clear drops and must not be re-accepted.
  task automatic test_clear_priority();
    do_reset();
    key_n = ~4'b0001;
    for (int i = 0; i < 16; i++) begin
      clearEntry = (i >= 4 && i < 12);
      step();
    end
    clearEntry = 1'b0;
    hold(4'b0000, 10);
    checks++; if (n_press !== 0) begin errors++; $display("FAIL clear_npress: got %0d want 0", n_press); end
    checks++; if (keyValueStore !== 24'h0) begin errors++; $display("FAIL clear_store: got %h want %h", keyValueStore, 24'h0); end
    checks++; if (keyCount !== 3'd0) begin errors++; $display("FAIL clear_count: got %0d want 0", keyCount); end
    hold(4'b0010, 10);
    hold(4'b0000, 10);
    checks++; if (keyValueStore !== 24'h000002) begin errors++; $display("FAIL clear_idle_store: got %h want %h", keyValueStore, 24'h000002); end
  endtask

  task automatic test_reset_mid_entry();
    do_reset();
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    hold(4'b0010, 10);
    hold(4'b0000, 10);
    checks++; if (keyCount !== 3'd2) begin errors++; $display("FAIL mid_count: got %0d want 2", keyCount); end
    checks++; if (keyValueStore !== 24'h000012) begin errors++; $display("FAIL mid_store: got %h want %h", keyValueStore, 24'h000012); end
    reset = 1'b1;
    step();
    checks++; if (keyValueStore !== 24'h0) begin errors++; $display("FAIL mid_rst_store: got %h want %h", keyValueStore, 24'h0); end
    checks++; if (keyCount !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", keyCount); end
    checks++; if ({keyPressed, entryDone, entryTimeout} !== 3'b000) begin errors++; $display("FAIL mid_rst_pulses: got %b want 000", {keyPressed, entryDone, entryTimeout}); end
    reset = 1'b0;
  endtask

  task automatic test_enable_low();
    do_reset();
    enable = 1'b0;
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    checks++; if (n_press !== 0) begin errors++; $display("FAIL enlow_npress: got %0d want 0", n_press); end
    checks++; if (keyValueStore !== 24'h0) begin errors++; $display("FAIL enlow_store: got %h want %h", keyValueStore, 24'h0); end
    enable = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    reset = 1'b1;
    key_n = 4'hF;
    enable = 1'b1;
    clearEntry = 1'b0;
    clear_mon();
    test_reset();
    test_full_entry();
    test_bounce();
    test_timeout();
    test_two_keys();
    test_clear_priority();
    test_reset_mid_entry();
    test_enable_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
